audio_ram_sched: RTL and testbench
==================================

# audio_ram_sched

Two-port scheduler that shares the single DDR memory-interface command port between the audio record path (sample writes) and the playback path (sample reads). It sits between the recorder/player FSM datapaths and the RAM interface in the top-level controller. It arbitrates round-robin, holds one command outstanding at a time, range-checks addresses and guards against a hung memory with a timeout.

## Interface
- ADDR_W, 26, address width (word addresses)
- DATA_W, 16, audio sample width
- MAX_ADDR, 26'h3FFFFFF, highest legal address; anything above is rejected
- TIMEOUT, 1023, cycles to wait for mem_done before aborting (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- wr_req  in  1  record path requests a write; level, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req
- wr_data  in  DATA_W  write sample, stable while wr_req
- wr_ack  out  1  one-cycle pulse: write finished (or rejected, see err)
- rd_req  in  1  playback path requests a read; level, held until rd_ack
- rd_addr  in  ADDR_W  read address, stable while rd_req
- rd_ack  out  1  one-cycle pulse: read finished; rd_data valid this cycle
- rd_data  out  DATA_W  read sample; holds last value between reads
- err  out  1  one-cycle pulse coincident with wr_ack/rd_ack when the access was rejected (range) or aborted (timeout)
- mem_ready  in  1  RAM status: calibrated and able to take commands
- mem_cmd_valid  out  1  command presented to RAM; held until mem_done or timeout
- mem_cmd_we  out  1  1 = write, 0 = read; valid with mem_cmd_valid
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  write data
- mem_done  in  1  RAM single-cycle pulse: command complete; mem_rdata valid this cycle for reads
- mem_rdata  in  DATA_W  read data from RAM

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if mem_ready=0, no grant. Else if exactly one req high, grant it. If both high, grant the port not granted last (last_grant register, reset value = read, so first contested grant goes to write).
- At grant: latch addr/data/we into command registers; update last_grant.
  - Address > MAX_ADDR: no memory command; go RESP with err=1.
  - Otherwise: mem_cmd_valid=1, go BUSY, clear timeout counter.
- BUSY: mem_cmd_valid/we/addr/wdata held constant. On mem_done: capture mem_rdata into rd_data if read; drop mem_cmd_valid; go RESP, err=0. If counter reaches TIMEOUT without mem_done: drop mem_cmd_valid; go RESP, err=1; rd_data unchanged.
- mem_done outside BUSY is ignored.
- RESP: assert exactly one of wr_ack/rd_ack (the granted port) for one cycle, err as decided; next state IDLE unconditionally.
- mem_ready dropping during BUSY does not abort; only mem_done or timeout ends the command.
- Reset (async, any state): state=IDLE, last_grant=read, all outputs 0 (mem_cmd_valid, mem_cmd_we, mem_addr, mem_wdata, wr_ack, rd_ack, rd_data, err), timeout counter 0. A command in flight is abandoned; no ack is issued for it.

## Timing
- All outputs registered.
- Grant: req sampled high at edge t in IDLE → mem_cmd_valid high after t.
- mem_done sampled at edge t+k → mem_cmd_valid low and ack high after t+k; ack low after t+k+1.
- Write latency, req to ack = k+1 cycles, with k ≥ 1 the RAM latency. Range reject: ack 2 cycles after req is sampled.
- Requester must deassert (or change) req at the first edge after sampling ack. The scheduler re-samples requests at the edge after RESP, so a registered requester never causes a duplicate grant.
- Timeout: with no mem_done, ack+err are high after edge t+TIMEOUT+1.
- Back-to-back contested throughput: one access per k+2 cycles, strictly alternating.

## Test plan
- Single write: mem_ready=1, wr_req with addr 0x10, data 0xBEEF; RAM returns mem_done 3 cycles after valid → mem_cmd_valid/we=1, mem_addr=0x10, mem_wdata=0xBEEF held 3 cycles; wr_ack pulses once; err=0.
- Single read: rd_addr 0x20, mem_rdata 0x1234 with mem_done → rd_ack pulse with rd_data=0x1234; rd_data still 0x1234 after 10 idle cycles.
- Contention: wr_req and rd_req both held for 4 accesses each → grant order W,R,W,R,…; no port granted twice in a row; each ack pulses exactly once per access.
- Boundary: MAX_ADDR=0xFF, wr_addr 0x100 → no mem_cmd_valid, wr_ack+err after 2 cycles; wr_addr 0xFF → normal access, err=0.
- Timeout: TIMEOUT=8, never assert mem_done → mem_cmd_valid high exactly 8 cycles, then rd_ack+err pulse; rd_data unchanged; a following read completes normally.
- Reset mid-BUSY and mem_ready gating: assert reset during BUSY → all outputs 0 immediately, no ack afterward. With mem_ready=0 and wr_req high → no grant until mem_ready=1, then grant on the next edge.

Source files
------------

// File: rtl/audio_ram_sched.sv
// Round-robin scheduler sharing one RAM command port between the record (write)
// and playback (read) paths, one command outstanding, with range check and timeout.
module audio_ram_sched #(
  parameter int                ADDR_W   = 26,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 26'h3FFFFFF,
  parameter int                TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  input  logic              mem_ready,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state;
  logic              r_last_rd;
  logic              r_is_rd;
  logic              r_fail;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_any;
  logic              w_pick_rd;
  logic [ADDR_W-1:0] w_addr;
  logic              w_oor;

  // On contention the port that did not win last time gets the grant.
  assign w_any     = wr_req | rd_req;
  assign w_pick_rd = rd_req & (~wr_req | ~r_last_rd);
  assign w_addr    = w_pick_rd ? rd_addr : wr_addr;
  assign w_oor     = {1'b0, w_addr} > {1'b0, MAX_ADDR};

  // Rejected or timed-out accesses spend an extra RESP cycle before the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_rd     <= 1'b1;
      r_is_rd       <= 1'b0;
      r_fail        <= 1'b0;
      r_cnt         <= '0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      rd_data       <= '0;
      err           <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_ready && w_any) begin
            r_is_rd    <= w_pick_rd;
            r_last_rd  <= w_pick_rd;
            mem_cmd_we <= ~w_pick_rd;
            mem_addr   <= w_addr;
            if (!w_pick_rd) begin
              mem_wdata <= wr_data;
            end
            r_cnt  <= '0;
            r_fail <= w_oor;
            if (w_oor) begin
              r_state <= S_RESP;
            end else begin
              mem_cmd_valid <= 1'b1;
              r_state       <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mem_done) begin
            mem_cmd_valid <= 1'b0;
            if (r_is_rd) begin
              rd_data <= mem_rdata;
            end
            wr_ack  <= ~r_is_rd;
            rd_ack  <= r_is_rd;
            err     <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            mem_cmd_valid <= 1'b0;
            r_fail        <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (wr_ack || rd_ack) begin
            wr_ack  <= 1'b0;
            rd_ack  <= 1'b0;
            err     <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            wr_ack <= ~r_is_rd;
            rd_ack <= r_is_rd;
            err    <= r_fail;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_ram_sched.sv
// Directed bench for audio_ram_sched built with MAX_ADDR=0xFF and TIMEOUT=8.
module tb_audio_ram_sched;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_req, rd_req, mem_ready, mem_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, mem_rdata;
  logic              wr_ack, rd_ack, err, mem_cmd_valid, mem_cmd_we;
  logic [DATA_W-1:0] rd_data, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_rd;
  int wr_left, rd_left;
  logic exp_rd_port;

  audio_ram_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(26'hFF), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .err(err), .mem_ready(mem_ready), .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_we(mem_cmd_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(mem_cmd_valid), 32'd0);
    chk({tag, ".we"},    32'(mem_cmd_we),    32'd0);
    chk({tag, ".addr"},  32'(mem_addr),      32'd0);
    chk({tag, ".wdata"}, 32'(mem_wdata),     32'd0);
    chk({tag, ".acks"},  32'({wr_ack, rd_ack, err}), 32'd0);
    chk({tag, ".rdata"}, 32'(rd_data),       32'd0);
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; mem_ready = 1'b1; mem_done = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; mem_rdata = '0;
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Single write, RAM latency 3
    wr_req = 1'b1; wr_addr = 26'h10; wr_data = 16'hBEEF;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("wr.valid", 32'(mem_cmd_valid), 32'd1);
      chk("wr.we",    32'(mem_cmd_we),    32'd1);
      chk("wr.addr",  32'(mem_addr),      32'h10);
      chk("wr.wdata", 32'(mem_wdata),     32'hBEEF);
      chk("wr.noack", 32'(wr_ack),        32'd0);
      if (i == 2) mem_done = 1'b1;
      step();
    end
    mem_done = 1'b0;
    chk("wr.ack",   32'({wr_ack, rd_ack, err}), 32'b100);
    chk("wr.vdrop", 32'(mem_cmd_valid), 32'd0);
    wr_req = 1'b0;
    step();
    chk("wr.ackoff", 32'(wr_ack), 32'd0);
    step();

    // Single read
    rd_req = 1'b1; rd_addr = 26'h20;
    step();
    chk("rd.valid", 32'(mem_cmd_valid), 32'd1);
    chk("rd.we",    32'(mem_cmd_we),    32'd0);
    chk("rd.addr",  32'(mem_addr),      32'h20);
    mem_done = 1'b1; mem_rdata = 16'h1234;
    step();
    mem_done = 1'b0; mem_rdata = 16'hDEAD;
    chk("rd.ack",  32'({wr_ack, rd_ack, err}), 32'b010);
    chk("rd.data", 32'(rd_data), 32'h1234);
    rd_req = 1'b0;
    step();
    chk("rd.ackoff", 32'(rd_ack), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("rd.hold", 32'(rd_data), 32'h1234);

    // Contention: 4 writes + 4 reads, alternating starting with write
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 26'h40; rd_addr = 26'h50;
    wr_left = 4; rd_left = 4; exp_rd_port = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ct.valid", 32'(mem_cmd_valid), 32'd1);
      chk("ct.we",    32'(mem_cmd_we),    32'(!exp_rd_port));
      mem_done = 1'b1; mem_rdata = 16'hA000 + 16'(i);
      step();
      mem_done = 1'b0;
      if (exp_rd_port) begin
        exp_rd = 16'hA000 + 16'(i);
        chk("ct.ack", 32'({wr_ack, rd_ack, err}), 32'b010);
        chk("ct.rdata", 32'(rd_data), 32'(exp_rd));
        rd_left--; rd_req = 1'b0;
      end else begin
        chk("ct.ack", 32'({wr_ack, rd_ack, err}), 32'b100);
        wr_left--; wr_req = 1'b0;
      end
      step();
      chk("ct.ackoff", 32'({wr_ack, rd_ack}), 32'd0);
      wr_req = (wr_left > 0); rd_req = (rd_left > 0);
      exp_rd_port = !exp_rd_port;
    end
    chk("ct.counts", 32'(wr_left + rd_left), 32'd0);
    step();

    // Range reject and boundary address
    wr_req = 1'b1; wr_addr = 26'h100; wr_data = 16'h0101;
    step();
    chk("oor.novalid0", 32'({mem_cmd_valid, wr_ack}), 32'd0);
    step();
    chk("oor.ack",      32'({wr_ack, rd_ack, err}), 32'b101);
    chk("oor.novalid1", 32'(mem_cmd_valid), 32'd0);
    wr_req = 1'b0;
    step();
    chk("oor.ackoff", 32'({wr_ack, err}), 32'd0);
    wr_req = 1'b1; wr_addr = 26'hFF; wr_data = 16'h00FF;
    step();
    chk("max.valid", 32'(mem_cmd_valid), 32'd1);
    chk("max.addr",  32'(mem_addr), 32'hFF);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    chk("max.ack", 32'({wr_ack, rd_ack, err}), 32'b100);
    wr_req = 1'b0;
    step();

    // Timeout on a read, then a normal read
    rd_req = 1'b1; rd_addr = 26'h30;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to.valid", 32'(mem_cmd_valid), 32'd1);
      chk("to.noack", 32'(rd_ack), 32'd0);
    end
    step();
    chk("to.vdrop", 32'({mem_cmd_valid, rd_ack}), 32'd0);
    step();
    chk("to.ack",   32'({wr_ack, rd_ack, err}), 32'b011);
    chk("to.rdata", 32'(rd_data), 32'(exp_rd));
    rd_req = 1'b0;
    step();
    chk("to.ackoff", 32'({rd_ack, err}), 32'd0);
    rd_req = 1'b1; rd_addr = 26'h31;
    step();
    chk("to2.valid", 32'(mem_cmd_valid), 32'd1);
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    step();
    mem_done = 1'b0;
    chk("to2.ack",   32'({wr_ack, rd_ack, err}), 32'b010);
    chk("to2.rdata", 32'(rd_data), 32'h5A5A);
    rd_req = 1'b0;
    step();

    // mem_ready gating
    mem_ready = 1'b0; wr_req = 1'b1; wr_addr = 26'h44; wr_data = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy.nogrant", 32'(mem_cmd_valid), 32'd0);
    end
    mem_ready = 1'b1;
    step();
    chk("rdy.grant", 32'(mem_cmd_valid), 32'd1);
    chk("rdy.addr",  32'(mem_addr), 32'h44);
    step();

    // Reset mid-BUSY: outputs clear at once, no ack afterwards
    reset = 1'b1;
    #1;
    chk_all_zero("rst");
    wr_req = 1'b0;
    step();
    reset = 1'b0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst.noack", 32'({wr_ack, rd_ack, err, mem_cmd_valid}), 32'd0);
      step();
    end
    // Contested grant after reset goes to write again
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 26'h60; rd_addr = 26'h61;
    step();
    chk("rst.firstw", 32'({mem_cmd_valid, mem_cmd_we}), 32'b11);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    chk("rst.wack", 32'({wr_ack, rd_ack}), 32'b10);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
